// File: rtl/sd_pcm_serializer.sv
// rtl/sd_pcm_serializer.sv - PCM word FIFO and framed MSB-first serializer (optional parity: SD_PCM_PARITY_EN)
module sd_pcm_serializer #(
    parameter int DW       = 16,
    parameter int DEPTH    = 8,
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DW-1:0]            din,
    input  logic                     din_valid,
    input  logic                     enable,
    input  logic                     ovf_clr,
    output logic                     sclk,
    output logic                     fs,
    output logic                     sdo,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf
);
    localparam int AW = $clog2(DEPTH);
`ifdef SD_PCM_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(NB);
    localparam int GW = $clog2(GAP_BITS + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, pop, wr, wrap, gap_done;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bitcnt;
    logic [GW-1:0] gapcnt;
    logic [NB-1:0] shreg;
    logic [NB-1:0] head_word;

    assign fifo_level = wptr - rptr;
    assign empty      = (wptr == rptr);
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wrap       = (cnt == CW'(CLK_DIV - 1));
    assign gap_done   = (state == GAP) && wrap && (gapcnt == GW'(GAP_BITS - 1));
    assign pop        = enable && !empty && ((state == IDLE) || gap_done);
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign wr         = din_valid && (!full || pop);

`ifdef SD_PCM_PARITY_EN
    assign head_word  = {mem[rptr[AW-1:0]], ^mem[rptr[AW-1:0]]};
`else
    assign head_word  = mem[rptr[AW-1:0]];
`endif

    assign sclk = (state != IDLE) && (cnt < CW'(CLK_DIV / 2));
    assign sdo  = (state == SHIFT) && shreg[NB-1];
    assign fs   = (state == SHIFT) && (bitcnt == '0);

    // FIFO storage and pointers; a dropped write leaves everything untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wptr[AW-1:0]] <= din;
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    // Sticky overflow; a simultaneous overflowing write beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ovf <= 1'b0;
        else if (din_valid && full && !pop) ovf <= 1'b1;
        else if (ovf_clr)                ovf <= 1'b0;
    end

    // Frame sequencer: bit divider, shift register and IDLE/SHIFT/GAP control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
            shreg  <= '0;
        end else begin
            cnt <= (state == IDLE || wrap) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg  <= head_word;
                        bitcnt <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (wrap) begin
                        if (bitcnt == BW'(NB - 1)) begin
                            gapcnt <= '0;
                            state  <= GAP;
                        end else begin
                            shreg  <= {shreg[NB-2:0], 1'b0};
                            bitcnt <= bitcnt + BW'(1);
                        end
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (pop) begin
                            shreg  <= head_word;
                            bitcnt <= '0;
                            state  <= SHIFT;
                        end else begin
                            state  <= IDLE;
                        end
                    end else if (wrap) begin
                        gapcnt <= gapcnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_pcm_serializer.sv
// tb/tb_sd_pcm_serializer.sv - scoreboard bench for sd_pcm_serializer
module tb_sd_pcm_serializer;
    localparam int DW = 16, DEPTH = 8, CLK_DIV = 4, GAP_BITS = 2;
`ifdef SD_PCM_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif
    localparam int FRAME_CLK = (NB + GAP_BITS) * CLK_DIV;

    logic clk = 0, rst_n = 0;
    logic [DW-1:0] din = '0;
    logic din_valid = 0, enable = 0, ovf_clr = 0;
    logic sclk, fs, sdo, ovf;
    logic [$clog2(DEPTH):0] fifo_level;

    sd_pcm_serializer #(.DW(DW), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .GAP_BITS(GAP_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .enable(enable),
        .ovf_clr(ovf_clr), .sclk(sclk), .fs(fs), .sdo(sdo), .fifo_level(fifo_level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [NB-1:0] sb[$];
    logic [NB-1:0] last_frame, shbuf;
    int nbit = 0, in_frame = 0, cyc = 0, sclk_rises = 0, nframes = 0, fs_len = 0;
    int rise_t[64];
    logic sclk_q = 0, fs_q = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NB-1:0] exp_word(input logic [DW-1:0] d);
`ifdef SD_PCM_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    // Monitor: collect bits on sclk falling edges, measure fs width and frame spacing.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (sclk && !sclk_q) sclk_rises++;
            if (fs && !fs_q) begin
                if (nframes < 64) rise_t[nframes] = cyc;
                nframes++;
                fs_len = 0;
            end
            if (fs) fs_len++;
            if (!fs && fs_q) chk("fs_width", fs_len, CLK_DIV);
            if (sclk_q && !sclk) begin
                if (fs) begin
                    in_frame = 1;
                    nbit = 0;
                end
                if (in_frame != 0) begin
                    shbuf = {shbuf[NB-2:0], sdo};
                    nbit++;
                    if (nbit == NB) begin
                        in_frame = 0;
                        last_frame = shbuf;
                        if (sb.size() == 0) chk("unexpected_frame", {{(32-NB){1'b0}}, shbuf}, 32'hFFFF_FFFF);
                        else chk("frame_data", {{(32-NB){1'b0}}, shbuf}, {{(32-NB){1'b0}}, sb.pop_front()});
                    end
                end
            end
        end
        sclk_q = sclk;
        fs_q = fs;
    end

    task automatic write_word(input logic [DW-1:0] d, input bit expect_accept);
        din = d;
        din_valid = 1;
        if (expect_accept) sb.push_back(exp_word(d));
        @(negedge clk);
        din_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || in_frame != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t < 3000, 1);
        repeat ((GAP_BITS + 1) * CLK_DIV + 2) @(negedge clk);
    endtask

    initial begin
        int r0, f0, t;
        // Reset with a din_valid pulse inside it
        @(negedge clk);
        din = 16'h1111; din_valid = 1;
        @(negedge clk);
        din_valid = 0;
        chk("rst_sclk", sclk, 0);
        chk("rst_fs", fs, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1;
        r0 = sclk_rises;
        repeat (10) @(negedge clk);
        chk("idle_no_sclk", sclk_rises - r0, 0);
        chk("idle_level", fifo_level, 0);

        // Single word with latency check
        enable = 1;
        r0 = sclk_rises;
        write_word(16'hA5C3, 1);
        chk("single_level", fifo_level, 1);
        @(negedge clk);
        chk("latency_fs", fs, 1);
        chk("latency_sdo", sdo, 1);
        wait_idle();
        chk("single_sclk_periods", sclk_rises - r0, NB + GAP_BITS);
        chk("single_idle_sclk", sclk, 0);

        // Back-to-back frames
        enable = 0;
        f0 = nframes;
        write_word(16'h8001, 1);
        chk("b2b_level1", fifo_level, 1);
        write_word(16'h7FFE, 1);
        chk("b2b_level2", fifo_level, 2);
        enable = 1;
        @(negedge clk);
        chk("b2b_level_pop1", fifo_level, 1);
        t = 0;
        while (fifo_level != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_level_pop2", fifo_level, 0);
        wait_idle();
        chk("b2b_frames", nframes - f0, 2);
        chk("b2b_spacing", rise_t[f0 + 1] - rise_t[f0], FRAME_CLK);

        // Overflow
        enable = 0;
        for (int i = 0; i < 9; i++) begin
            din = DW'(i);
            din_valid = 1;
            if (i < DEPTH) sb.push_back(exp_word(DW'(i)));
            if (i == 8) begin
                chk("full_level", fifo_level, 8);
                chk("full_no_ovf", ovf, 0);
            end
            @(negedge clk);
        end
        din_valid = 0;
        chk("ovf_level", fifo_level, 8);
        chk("ovf_set", ovf, 1);
        din = 16'hDEAD; din_valid = 1; ovf_clr = 1;
        @(negedge clk);
        din_valid = 0; ovf_clr = 0;
        chk("ovf_set_wins", ovf, 1);
        ovf_clr = 1;
        @(negedge clk);
        ovf_clr = 0;
        chk("ovf_cleared", ovf, 0);
        // Write while full, same cycle as the first pop
        enable = 1;
        write_word(16'h1234, 1);
        chk("fullpop_level", fifo_level, 8);
        chk("fullpop_no_ovf", ovf, 0);
        wait_idle();
        chk("ovf_drained", fifo_level, 0);

`ifdef SD_PCM_PARITY_EN
        write_word(16'h0007, 1);
        wait_idle();
        chk("parity_0007", last_frame[0], 1);
        write_word(16'h0003, 1);
        wait_idle();
        chk("parity_0003", last_frame[0], 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
